// File: rtl/agc_pkg.sv
// agc_pkg: shared timepulse and word constants for the reduced AGC core
package agc_pkg;
   localparam int TP_COUNT   = 12;
   localparam int TP_CAPTURE = 5;
   localparam int WORD_W     = 16;
   typedef logic [TP_COUNT-1:0] tp_t;
   typedef logic [WORD_W-1:0]   word_t;
   localparam tp_t TP_RESET = tp_t'(1) << (TP_COUNT - 1);
endpackage

// File: rtl/agc_sim_if.sv
// agc_sim_if: AGC control, write-bus, reserved-pulse and status signals
interface agc_sim_if
   import agc_pkg::*;
#(parameter int RSTCNT_W = 8);
   logic VCC, GND, STRT1, STRT2, MSTRTP, EXT, SBY, MSTP;
   logic WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n;
   logic WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n, WL15, WL16;
   logic ALGA, C24A, C25A, C26A, C27A, C28A, C29A, C30A;
   logic C37P, C38P, C39P, C40P, C41P, C42P, C43P, C44P;
   logic CHINC_n, EXTPLS, FETCH0, FETCH0_n, GEQZRO_n, INCSET_n, INHPLS, INKL;
   logic INKL_n, L15_n, MNHRPT, MONPCH, MONWBK, MTCSAI, OVNHRP, RCHAT_n;
   logic RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SHANC_n, SHIFT, SHIFT_n;
   logic ST1, ST2, STFET1_n, STORE1_n, SUMA16_n, SUMB16_n, TSGU_n, XB7_n;
   logic XT0_n, XT1_n, XT2_n, XT3_n, XT4_n, XT5_n, XT6_n, YB0_n, YT0_n, n7XP14;
   tp_t                 T;
   word_t               G;
   logic                GOJAM, FUTEXT, STBY;
   logic [RSTCNT_W-1:0] RSTCNT;
   // Reserved pulses terminate here until the modules that consume them exist
   logic unused_sink;
   assign unused_sink = ^{VCC, GND, WL15, WL16,
      ALGA, C24A, C25A, C26A, C27A, C28A, C29A, C30A,
      C37P, C38P, C39P, C40P, C41P, C42P, C43P, C44P,
      CHINC_n, EXTPLS, FETCH0, FETCH0_n, GEQZRO_n, INCSET_n, INHPLS, INKL,
      INKL_n, L15_n, MNHRPT, MONPCH, MONWBK, MTCSAI, OVNHRP, RCHAT_n,
      RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SHANC_n, SHIFT, SHIFT_n,
      ST1, ST2, STFET1_n, STORE1_n, SUMA16_n, SUMB16_n, TSGU_n, XB7_n,
      XT0_n, XT1_n, XT2_n, XT3_n, XT4_n, XT5_n, XT6_n, YB0_n, YT0_n, n7XP14};
   modport master (
      output VCC, GND, STRT1, STRT2, MSTRTP, EXT, SBY, MSTP,
      WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n,
      WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n, WL15, WL16,
      ALGA, C24A, C25A, C26A, C27A, C28A, C29A, C30A,
      C37P, C38P, C39P, C40P, C41P, C42P, C43P, C44P,
      CHINC_n, EXTPLS, FETCH0, FETCH0_n, GEQZRO_n, INCSET_n, INHPLS, INKL,
      INKL_n, L15_n, MNHRPT, MONPCH, MONWBK, MTCSAI, OVNHRP, RCHAT_n,
      RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SHANC_n, SHIFT, SHIFT_n,
      ST1, ST2, STFET1_n, STORE1_n, SUMA16_n, SUMB16_n, TSGU_n, XB7_n,
      XT0_n, XT1_n, XT2_n, XT3_n, XT4_n, XT5_n, XT6_n, YB0_n, YT0_n, n7XP14,
      input T, G, GOJAM, FUTEXT, STBY, RSTCNT
   );
   modport slave (
      input VCC, GND, STRT1, STRT2, MSTRTP, EXT, SBY, MSTP,
      WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n,
      WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n, WL15, WL16,
      ALGA, C24A, C25A, C26A, C27A, C28A, C29A, C30A,
      C37P, C38P, C39P, C40P, C41P, C42P, C43P, C44P,
      CHINC_n, EXTPLS, FETCH0, FETCH0_n, GEQZRO_n, INCSET_n, INHPLS, INKL,
      INKL_n, L15_n, MNHRPT, MONPCH, MONWBK, MTCSAI, OVNHRP, RCHAT_n,
      RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SHANC_n, SHIFT, SHIFT_n,
      ST1, ST2, STFET1_n, STORE1_n, SUMA16_n, SUMB16_n, TSGU_n, XB7_n,
      XT0_n, XT1_n, XT2_n, XT3_n, XT4_n, XT5_n, XT6_n, YB0_n, YT0_n, n7XP14,
      output T, G, GOJAM, FUTEXT, STBY, RSTCNT
   );
endinterface

// File: rtl/agc_sync.sv
// agc_sync: multi-stage input synchroniser with asynchronous active-low clear
module agc_sync #(parameter int STAGES = 2) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = STAGES'({sync_q, d});
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/agc_sim.sv
// agc_sim: timepulse ring, GOJAM restart, write-bus capture and extend flag
module agc_sim
   import agc_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RSTCNT_W    = 8
) (
   input logic      CLOCK,
   input logic      SIM_RST_n,
   agc_sim_if.slave bus
);
   logic [5:0] raw, syn;
   logic start_s, ext_s, stop_s, hold;
   tp_t   t_q, t_d;
   word_t g_q, g_d, wl_n;
   logic  gojam_q, gojam_d, futext_q, futext_d, stby_q, stby_d;
   logic [RSTCNT_W-1:0] rstcnt_q, rstcnt_d;
   assign raw = {bus.MSTP, bus.SBY, bus.EXT, bus.MSTRTP, bus.STRT2, bus.STRT1};
   genvar i;
   for (i = 0; i < 6; i++) begin : g_sync
      agc_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk(CLOCK), .rst_n(SIM_RST_n), .d(raw[i]), .q(syn[i])
      );
   end
   assign start_s = |syn[2:0];
   assign ext_s   = syn[3];
   assign stop_s  = |syn[5:4];
   assign wl_n = {bus.WL16_n, bus.WL15_n, bus.WL14_n, bus.WL13_n, bus.WL12_n, bus.WL11_n,
                  bus.WL10_n, bus.WL09_n, bus.WL08_n, bus.WL07_n, bus.WL06_n, bus.WL05_n,
                  bus.WL04_n, bus.WL03_n, bus.WL02_n, bus.WL01_n};
   // GOJAM only releases at a T12 edge so a restart always spans whole memory cycles
   always_comb begin
      hold     = stop_s & t_q[TP_COUNT-1];
      t_d      = hold ? t_q : {t_q[TP_COUNT-2:0], t_q[TP_COUNT-1]};
      stby_d   = hold;
      gojam_d  = start_s | (gojam_q & ~t_q[TP_COUNT-1]);
      rstcnt_d = (gojam_d & ~gojam_q & ~&rstcnt_q) ? rstcnt_q + RSTCNT_W'(1) : rstcnt_q;
      g_d      = gojam_q ? '0 : t_q[TP_CAPTURE-1] ? ~wl_n : g_q;
      futext_d = gojam_q ? 1'b0 : ext_s ? 1'b1 : futext_q;
   end
   always_ff @(posedge CLOCK or negedge SIM_RST_n)
      if (!SIM_RST_n) begin
         t_q      <= TP_RESET;
         gojam_q  <= 1'b0;
         g_q      <= '0;
         futext_q <= 1'b0;
         stby_q   <= 1'b0;
         rstcnt_q <= '0;
      end else begin
         t_q      <= t_d;
         gojam_q  <= gojam_d;
         g_q      <= g_d;
         futext_q <= futext_d;
         stby_q   <= stby_d;
         rstcnt_q <= rstcnt_d;
      end
   assign bus.T      = t_q;
   assign bus.GOJAM  = gojam_q;
   assign bus.G      = g_q;
   assign bus.FUTEXT = futext_q;
   assign bus.STBY   = stby_q;
   assign bus.RSTCNT = rstcnt_q;
endmodule

// File: tb/tb_agc_sim.sv
// tb_agc_sim: directed and random stimulus against a phase-level reference model
module tb_agc_sim;
   localparam int SYNC = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errs = 0;
   int checks = 0;
   agc_sim_if bus ();
   agc_sim dut (.CLOCK(clk), .SIM_RST_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int phase, m_rc;
   logic m_goj, m_fut, m_stby;
   logic [15:0] m_g;
   logic [SYNC-1:0] h_st, h_ex, h_sp;

   task automatic m_reset();
      phase = 12; m_rc = 0; m_goj = 0; m_fut = 0; m_stby = 0; m_g = '0;
      h_st = '0; h_ex = '0; h_sp = '0;
   endtask

   function automatic logic [15:0] get_wl_n();
      return {bus.WL16_n, bus.WL15_n, bus.WL14_n, bus.WL13_n, bus.WL12_n, bus.WL11_n,
              bus.WL10_n, bus.WL09_n, bus.WL08_n, bus.WL07_n, bus.WL06_n, bus.WL05_n,
              bus.WL04_n, bus.WL03_n, bus.WL02_n, bus.WL01_n};
   endfunction

   task automatic set_wl(input logic [15:0] w);
      {bus.WL16_n, bus.WL15_n, bus.WL14_n, bus.WL13_n, bus.WL12_n, bus.WL11_n,
       bus.WL10_n, bus.WL09_n, bus.WL08_n, bus.WL07_n, bus.WL06_n, bus.WL05_n,
       bus.WL04_n, bus.WL03_n, bus.WL02_n, bus.WL01_n} = w;
   endtask

   task automatic rand_rsv();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      {bus.VCC, bus.GND, bus.WL15, bus.WL16,
       bus.ALGA, bus.C24A, bus.C25A, bus.C26A, bus.C27A, bus.C28A, bus.C29A, bus.C30A,
       bus.C37P, bus.C38P, bus.C39P, bus.C40P, bus.C41P, bus.C42P, bus.C43P, bus.C44P,
       bus.CHINC_n, bus.EXTPLS, bus.FETCH0, bus.FETCH0_n, bus.GEQZRO_n, bus.INCSET_n, bus.INHPLS, bus.INKL,
       bus.INKL_n, bus.L15_n, bus.MNHRPT, bus.MONPCH, bus.MONWBK, bus.MTCSAI, bus.OVNHRP, bus.RCHAT_n,
       bus.RCHBT_n, bus.RELPLS, bus.RUPTOR_n, bus.S11, bus.S12, bus.SHANC_n, bus.SHIFT, bus.SHIFT_n,
       bus.ST1, bus.ST2, bus.STFET1_n, bus.STORE1_n, bus.SUMA16_n, bus.SUMB16_n, bus.TSGU_n, bus.XB7_n,
       bus.XT0_n, bus.XT1_n, bus.XT2_n, bus.XT3_n, bus.XT4_n, bus.XT5_n, bus.XT6_n, bus.YB0_n, bus.YT0_n,
       bus.n7XP14} = r[61:0];
   endtask

   // One rising edge of the reference: every rule uses pre-edge state and synced inputs
   task automatic m_edge();
      logic st, ex, sp, hold, ng;
      st = h_st[SYNC-1]; ex = h_ex[SYNC-1]; sp = h_sp[SYNC-1];
      hold = sp && phase == 12;
      ng = st || (m_goj && phase != 12);
      if (ng && !m_goj && m_rc < 255) m_rc++;
      if (m_goj) m_g = '0; else if (phase == 5) m_g = ~get_wl_n();
      if (m_goj) m_fut = 0; else if (ex) m_fut = 1;
      m_stby = hold;
      phase = hold ? 12 : phase % 12 + 1;
      m_goj = ng;
      h_st = {h_st[SYNC-2:0], bus.STRT1 | bus.STRT2 | bus.MSTRTP};
      h_ex = {h_ex[SYNC-2:0], bus.EXT};
      h_sp = {h_sp[SYNC-2:0], bus.SBY | bus.MSTP};
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all();
      logic [11:0] te;
      te = '0;
      te[phase-1] = 1'b1;
      chk("T", 32'(bus.T), 32'(te));
      chk("GOJAM", 32'(bus.GOJAM), 32'(m_goj));
      chk("G", 32'(bus.G), 32'(m_g));
      chk("FUTEXT", 32'(bus.FUTEXT), 32'(m_fut));
      chk("STBY", 32'(bus.STBY), 32'(m_stby));
      chk("RSTCNT", 32'(bus.RSTCNT), 32'(m_rc));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         m_edge();
         #1;
         chk_all();
      end
   endtask

   initial begin
      {bus.STRT1, bus.STRT2, bus.MSTRTP, bus.EXT, bus.SBY, bus.MSTP} = '0;
      set_wl(16'hFFFF);
      rand_rsv();
      m_reset();
      #12;
      chk_all();
      chk("reset_T", 32'(bus.T), 32'h800);
      @(negedge clk) rst_n = 1'b1;
      cyc(1);
      chk("first_T01", 32'(bus.T), 32'h001);
      for (int k = 0; k < 30; k++) begin rand_rsv(); cyc(1); end
      chk("idle_rstcnt", 32'(bus.RSTCNT), 32'h0);
      bus.STRT1 = 1'b1;
      cyc(2);
      chk("goj_before_3rd", 32'(bus.GOJAM), 32'h0);
      cyc(1);
      chk("goj_at_3rd", 32'(bus.GOJAM), 32'h1);
      cyc(17);
      bus.STRT1 = 1'b0;
      cyc(20);
      chk("goj_dropped", 32'(bus.GOJAM), 32'h0);
      chk("rstcnt_1", 32'(bus.RSTCNT), 32'h1);
      bus.STRT2 = 1'b1; cyc(6); bus.STRT2 = 1'b0; cyc(20);
      chk("rstcnt_2", 32'(bus.RSTCNT), 32'h2);
      set_wl(16'hCFFF);
      cyc(14);
      chk("G_3000", 32'(bus.G), 32'h3000);
      set_wl(16'hFFFF);
      bus.EXT = 1'b1; cyc(5); bus.EXT = 1'b0; cyc(10);
      chk("futext_set", 32'(bus.FUTEXT), 32'h1);
      bus.STRT1 = 1'b1;
      cyc(4);
      chk("futext_gojam", 32'(bus.FUTEXT), 32'h0);
      chk("G_gojam", 32'(bus.G), 32'h0);
      cyc(2); bus.STRT1 = 1'b0; cyc(20);
      bus.SBY = 1'b1; cyc(16);
      chk("sby_T12", 32'(bus.T), 32'h800);
      chk("sby_stby", 32'(bus.STBY), 32'h1);
      bus.SBY = 1'b0; cyc(3);
      chk("sby_T01", 32'(bus.T), 32'h001);
      chk("sby_clear", 32'(bus.STBY), 32'h0);
      bus.MSTP = 1'b1; cyc(16);
      chk("mstp_T12", 32'(bus.T), 32'h800);
      bus.MSTP = 1'b0; cyc(3);
      chk("mstp_T01", 32'(bus.T), 32'h001);
      for (int k = 0; k < 400; k++) begin
         rand_rsv();
         set_wl(16'($urandom()));
         bus.STRT1  = ($urandom_range(0, 40) == 0);
         bus.MSTRTP = ($urandom_range(0, 60) == 0);
         bus.EXT    = ($urandom_range(0, 20) == 0);
         bus.SBY    = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 5) == 0) : bus.SBY;
         bus.MSTP   = ($urandom_range(0, 50) == 0);
         cyc(1);
      end
      {bus.STRT1, bus.STRT2, bus.MSTRTP, bus.EXT, bus.SBY, bus.MSTP} = '0;
      cyc(20);
      bus.STRT1 = 1'b1;
      cyc(5);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      chk_all();
      chk("async_T", 32'(bus.T), 32'h800);
      chk("async_goj", 32'(bus.GOJAM), 32'h0);
      chk("async_rstcnt", 32'(bus.RSTCNT), 32'h0);
      bus.STRT1 = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc(5);
      for (int k = 0; k < 260; k++) begin
         bus.STRT1 = 1'b1; cyc(1); bus.STRT1 = 1'b0; cyc(17);
      end
      chk("rstcnt_sat", 32'(bus.RSTCNT), 32'hFF);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/agc_sim.md
Name: agc_sim

Overview:
- Reduced Apollo Guidance Computer core used as the top simulation target.
- Generates the 12-phase memory-cycle timepulse ring from CLOCK.
- Produces the GOJAM restart from the start/alarm inputs.
- Captures the active-low write bus into a 16-bit register and keeps the FUTEXT (extend) flag; the remaining control-pulse inputs are reserved sinks for later AGC modules.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for STRT1, STRT2, MSTRTP, EXT, SBY and MSTP.
- RSTCNT_W, 8, width of the saturating restart counter.

Ports:
- CLOCK  input  1  system clock (1.024 MHz nominal), rising-edge.
- SIM_RST_n  input  1  asynchronous, active-low reset.
- VCC, GND  input  1 each  power tie-offs; unused.
- STRT1, STRT2, MSTRTP  input  1 each  restart requests, active-high.
- EXT  input  1  extend request, active-high.
- SBY, MSTP  input  1 each  standby and monitor-stop, active-high.
- WL01_n..WL14_n, WL15_n, WL16_n  input  1 each  write bus, active-low.
- WL15, WL16  input  1 each  true-polarity copies; ignored.
- All other inputs (ALGA, C24A..C30A, C37P..C44P, CHINC_n, EXTPLS, FETCH0, FETCH0_n, GEQZRO_n, INCSET_n, INHPLS, INKL, INKL_n, L15_n, MNHRPT, MONPCH, MONWBK, MTCSAI, OVNHRP, RCHAT_n, RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SHANC_n, SHIFT, SHIFT_n, ST1, ST2, STFET1_n, STORE1_n, SUMA16_n, SUMB16_n, TSGU_n, XB7_n, XT0_n..XT6_n, YB0_n, YT0_n, n7XP14)  input  1 each  reserved; must not affect any output.
- T  output  12  one-hot timepulses; T[0] is T01, T[11] is T12.
- GOJAM  output  1  restart in progress.
- G  output  16  captured write-bus word, true polarity.
- FUTEXT  output  1  extend flag.
- STBY  output  1  standby/stop indicator.
- RSTCNT  output  RSTCNT_W  number of restarts.

Behaviour:
- Reset values: T = T12 only (12'h800), GOJAM = 0, G = 0, FUTEXT = 0, STBY = 0, RSTCNT = 0, all synchronisers cleared.
- Ring counter: advances one position per rising CLOCK edge, T12 wraps to T01. The first edge after reset release gives T01.
- Stop/standby: synced SBY or MSTP high while T12 is active holds the ring at T12 and sets STBY = 1. Deassertion releases the ring on the next edge and clears STBY.
- Start detect: the sync'd OR of STRT1, STRT2 and MSTRTP sets GOJAM on the edge after the last synchroniser stage, i.e. GOJAM rises on the 3rd rising edge after the input rises.
- GOJAM stays high while the request stays high, then clears on the first T12 edge after the request drops, so it always ends at a cycle boundary.
- RSTCNT increments on each GOJAM 0->1 transition and saturates at all-ones.
- Capture: on the edge where T05 is active and GOJAM = 0, G loads the inverted active-low bus. G[i-1] = ~WLii_n for i = 1..16. While GOJAM = 1, G clears to 0.
- FUTEXT: set on the edge where synced EXT = 1. It is cleared only by GOJAM, and GOJAM wins if both occur on the same edge.
- Other outputs are unaffected by stop/standby; capture only happens when T05 occurs.
- Async reset mid-operation returns everything to the reset values immediately.

Decomposition:
- Shared package agc_pkg: TP_COUNT = 12, TP_CAPTURE = 5 (T05 index), WORD_W = 16, and the T12 reset constant.
- One sub-module, agc_sync: SYNC_STAGES-deep synchroniser with async active-low clear, instantiated per async input.

Test Plan:
- Reset release -> T steps T01, T02 ... T12, then back to T01 every 12 edges; GOJAM = 0, G = 0, RSTCNT = 0.
- STRT1 = 1 for 20 cycles -> GOJAM = 1 from the 3rd edge; it drops on the first T12 after synced STRT1 = 0; RSTCNT = 1; a second pulse gives RSTCNT = 2.
- WL13_n = 0 and WL14_n = 0, rest 1, GOJAM = 0 -> after the next T05 edge G = 16'h3000.
- EXT pulse of 5 cycles -> FUTEXT = 1 and stays set. A later STRT1 pulse -> FUTEXT = 0 when GOJAM = 1, and G = 0.
- SBY = 1 -> ring holds at T12 and STBY = 1; SBY = 0 -> T01 and STBY = 0. Repeat with MSTP.
- Toggle all reserved inputs randomly with no start/EXT -> outputs identical to an idle run. Assert SIM_RST_n = 0 mid-GOJAM -> all outputs return to reset values immediately.
